// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_sb : register file with per-word pending (scoreboard) bits,      |
// |              two registered read ports and optional write forwarding.    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegW,
  input  logic [ADDR_W-1:0] DR,
  input  logic [DATA_W-1:0] Reg_In,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic              Lock,
  input  logic [ADDR_W-1:0] LockAddr,
  output logic [DATA_W-1:0] ReadReg1,
  output logic [DATA_W-1:0] ReadReg2,
  output logic              Pend1,
  output logic              Pend2,
  output logic              AnyPend
);

  localparam int c_DEPTH = 1 << ADDR_W;

  // Packed storage keeps the whole-array reset a single assignment.
  logic [c_DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [c_DEPTH-1:0]             r_pend;

  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic              r_pd1;
  logic              r_pd2;
  logic              r_any;

  logic               w_dr_ok;
  logic               w_la_ok;
  logic               w_sr1_zero;
  logic               w_sr2_zero;
  logic               w_wr_en;
  logic               w_lk_en;
  logic               w_fwd1;
  logic               w_fwd2;
  logic [c_DEPTH-1:0] w_pend_nxt;
  logic [c_DEPTH-1:0] w_pend_src;
  logic [DATA_W-1:0]  w_rd1_d;
  logic [DATA_W-1:0]  w_rd2_d;
  logic               w_pd1_d;
  logic               w_pd2_d;

  if (ZERO_REG != 0) begin : g_zero_reg
    assign w_dr_ok    = (DR != '0);
    assign w_la_ok    = (LockAddr != '0);
    assign w_sr1_zero = (SR1 == '0);
    assign w_sr2_zero = (SR2 == '0);
  end else begin : g_no_zero_reg
    assign w_dr_ok    = 1'b1;
    assign w_la_ok    = 1'b1;
    assign w_sr1_zero = 1'b0;
    assign w_sr2_zero = 1'b0;
  end

  assign w_wr_en = RegW && w_dr_ok;
  assign w_lk_en = Lock && w_la_ok;

  // Lock is applied after the write-clear so a coincident lock wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_en) begin
      w_pend_nxt[DR] = 1'b0;
    end
    if (w_lk_en) begin
      w_pend_nxt[LockAddr] = 1'b1;
    end
  end

  if (BYPASS != 0) begin : g_bypass
    assign w_fwd1     = w_wr_en && (SR1 == DR);
    assign w_fwd2     = w_wr_en && (SR2 == DR);
    assign w_pend_src = w_pend_nxt;
  end else begin : g_no_bypass
    assign w_fwd1     = 1'b0;
    assign w_fwd2     = 1'b0;
    assign w_pend_src = r_pend;
  end

  always_comb begin
    w_rd1_d = w_fwd1 ? Reg_In : r_mem[SR1];
    w_pd1_d = w_pend_src[SR1];
    if (w_sr1_zero) begin
      w_rd1_d = '0;
      w_pd1_d = 1'b0;
    end
  end

  always_comb begin
    w_rd2_d = w_fwd2 ? Reg_In : r_mem[SR2];
    w_pd2_d = w_pend_src[SR2];
    if (w_sr2_zero) begin
      w_rd2_d = '0;
      w_pd2_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem <= '0;
    end else if (w_wr_en) begin
      r_mem[DR] <= Reg_In;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend <= '0;
      r_any  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_any  <= |w_pend_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_pd1 <= 1'b0;
      r_pd2 <= 1'b0;
    end else if (RdEn) begin
      r_rd1 <= w_rd1_d;
      r_rd2 <= w_rd2_d;
      r_pd1 <= w_pd1_d;
      r_pd2 <= w_pd2_d;
    end
  end

  assign ReadReg1 = r_rd1;
  assign ReadReg2 = r_rd2;
  assign Pend1    = r_pd1;
  assign Pend2    = r_pd2;
  assign AnyPend  = r_any;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_sb : directed table, hand sequences and random traffic for    |
// |                 forwarding and non-forwarding regfile_sb instances.      |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_regfile_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegW;
  logic [4:0]  DR;
  logic [31:0] Reg_In;
  logic        RdEn;
  logic [4:0]  SR1;
  logic [4:0]  SR2;
  logic        Lock;
  logic [4:0]  LockAddr;

  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_p1, b_p2, b_any, n_p1, n_p2, n_any;

  int n_checks;
  int n_fail;
  int cyc;

  always #5 CLK = ~CLK;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .CLK(CLK), .RST(RST), .RegW(RegW), .DR(DR), .Reg_In(Reg_In), .RdEn(RdEn),
    .SR1(SR1), .SR2(SR2), .Lock(Lock), .LockAddr(LockAddr),
    .ReadReg1(b_rd1), .ReadReg2(b_rd2), .Pend1(b_p1), .Pend2(b_p2), .AnyPend(b_any)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .CLK(CLK), .RST(RST), .RegW(RegW), .DR(DR), .Reg_In(Reg_In), .RdEn(RdEn),
    .SR1(SR1), .SR2(SR2), .Lock(Lock), .LockAddr(LockAddr),
    .ReadReg1(n_rd1), .ReadReg2(n_rd2), .Pend1(n_p1), .Pend2(n_p2), .AnyPend(n_any)
  );

  // Reference model: architectural state plus expected outputs.
  // Index 0 = forwarding instance (reads see post-edge state), 1 = non-forwarding.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  logic [31:0] x_rd1 [2];
  logic [31:0] x_rd2 [2];
  bit          x_p1 [2];
  bit          x_p2 [2];
  bit          x_any;

  typedef struct {
    string       name;
    logic        rst, regw, rden, lock;
    logic [4:0]  dr, sr1, sr2, la;
    logic [31:0] din;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_p1, b_p2, n_p1, n_p2, any;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic rst, logic regw, logic [4:0] dr,
                              logic [31:0] din, logic rden, logic [4:0] sr1,
                              logic [4:0] sr2, logic lock, logic [4:0] la,
                              logic [31:0] brd1, logic [31:0] brd2, logic bp1, logic bp2,
                              logic [31:0] nrd1, logic [31:0] nrd2, logic np1, logic np2,
                              logic any);
    vec_t v;
    v.name = name; v.rst = rst; v.regw = regw; v.dr = dr; v.din = din;
    v.rden = rden; v.sr1 = sr1; v.sr2 = sr2; v.lock = lock; v.la = la;
    v.b_rd1 = brd1; v.b_rd2 = brd2; v.b_p1 = bp1; v.b_p2 = bp2;
    v.n_rd1 = nrd1; v.n_rd2 = nrd2; v.n_p1 = np1; v.n_p2 = np2; v.any = any;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(logic rst, logic regw, logic [4:0] dr, logic [31:0] din,
                        logic rden, logic [4:0] sr1, logic [4:0] sr2,
                        logic lock, logic [4:0] la);
    RST = rst; RegW = regw; DR = dr; Reg_In = din; RdEn = rden;
    SR1 = sr1; SR2 = sr2; Lock = lock; LockAddr = la;
  endtask

  task automatic model_step();
    logic [31:0] nmem [32];
    bit          npend [32];
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0;
        m_pend[i] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        x_rd1[k] = '0; x_rd2[k] = '0; x_p1[k] = 1'b0; x_p2[k] = 1'b0;
      end
      x_any = 1'b0;
      return;
    end
    nmem  = m_mem;
    npend = m_pend;
    if (RegW && DR != 5'd0) begin
      nmem[DR]  = Reg_In;
      npend[DR] = 1'b0;
    end
    if (Lock && LockAddr != 5'd0) npend[LockAddr] = 1'b1;
    if (RdEn) begin
      x_rd1[0] = nmem[SR1];  x_p1[0] = npend[SR1];
      x_rd2[0] = nmem[SR2];  x_p2[0] = npend[SR2];
      x_rd1[1] = m_mem[SR1]; x_p1[1] = m_pend[SR1];
      x_rd2[1] = m_mem[SR2]; x_p2[1] = m_pend[SR2];
    end
    x_any = 1'b0;
    for (int i = 0; i < 32; i++) x_any = x_any | npend[i];
    m_mem  = nmem;
    m_pend = npend;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    chk($sformatf("cyc%0d byp rd1", cyc), b_rd1, x_rd1[0]);
    chk($sformatf("cyc%0d byp rd2", cyc), b_rd2, x_rd2[0]);
    chk($sformatf("cyc%0d byp p1", cyc), 32'(b_p1), 32'(x_p1[0]));
    chk($sformatf("cyc%0d byp p2", cyc), 32'(b_p2), 32'(x_p2[0]));
    chk($sformatf("cyc%0d byp any", cyc), 32'(b_any), 32'(x_any));
    chk($sformatf("cyc%0d nob rd1", cyc), n_rd1, x_rd1[1]);
    chk($sformatf("cyc%0d nob rd2", cyc), n_rd2, x_rd2[1]);
    chk($sformatf("cyc%0d nob p1", cyc), 32'(n_p1), 32'(x_p1[1]));
    chk($sformatf("cyc%0d nob p2", cyc), 32'(n_p2), 32'(x_p2[1]));
    chk($sformatf("cyc%0d nob any", cyc), 32'(n_any), 32'(x_any));
  endtask

  task automatic chk_vec(vec_t v);
    chk({v.name, " byp rd1"}, b_rd1, v.b_rd1);
    chk({v.name, " byp rd2"}, b_rd2, v.b_rd2);
    chk({v.name, " byp p1"}, 32'(b_p1), 32'(v.b_p1));
    chk({v.name, " byp p2"}, 32'(b_p2), 32'(v.b_p2));
    chk({v.name, " nob rd1"}, n_rd1, v.n_rd1);
    chk({v.name, " nob rd2"}, n_rd2, v.n_rd2);
    chk({v.name, " nob p1"}, 32'(n_p1), 32'(v.n_p1));
    chk({v.name, " nob p2"}, 32'(n_p2), 32'(v.n_p2));
    chk({v.name, " byp any"}, 32'(b_any), 32'(v.any));
    chk({v.name, " nob any"}, 32'(n_any), 32'(v.any));
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);

    //                 rst regw dr  din            rden sr1 sr2 lk la   byp rd1/rd2/p1/p2                   nob rd1/rd2/p1/p2                   any
    vq.push_back(mk("reset",  1,0,0,32'h0,       0,0,0,0,0, 32'h0,32'h0,0,0,               32'h0,32'h0,0,0,               0));
    vq.push_back(mk("wr5",    0,1,5,32'hDEADBEEF,0,0,0,0,0, 32'h0,32'h0,0,0,               32'h0,32'h0,0,0,               0));
    vq.push_back(mk("rd5",    0,0,0,32'h0,       1,5,0,0,0, 32'hDEADBEEF,32'h0,0,0,        32'hDEADBEEF,32'h0,0,0,        0));
    vq.push_back(mk("wr7",    0,1,7,32'h11,      0,0,0,0,0, 32'hDEADBEEF,32'h0,0,0,        32'hDEADBEEF,32'h0,0,0,        0));
    vq.push_back(mk("byp7",   0,1,7,32'h22,      1,7,7,0,0, 32'h22,32'h22,0,0,             32'h11,32'h11,0,0,             0));
    vq.push_back(mk("wr0",    0,1,0,32'hFFFFFFFF,0,0,0,0,0, 32'h22,32'h22,0,0,             32'h11,32'h11,0,0,             0));
    vq.push_back(mk("lock0",  0,0,0,32'h0,       0,0,0,1,0, 32'h22,32'h22,0,0,             32'h11,32'h11,0,0,             0));
    vq.push_back(mk("rd0",    0,0,0,32'h0,       1,0,0,0,0, 32'h0,32'h0,0,0,               32'h0,32'h0,0,0,               0));
    vq.push_back(mk("lock3",  0,0,0,32'h0,       1,0,3,1,3, 32'h0,32'h0,0,1,               32'h0,32'h0,0,0,               1));
    vq.push_back(mk("rd3",    0,0,0,32'h0,       1,0,3,0,0, 32'h0,32'h0,0,1,               32'h0,32'h0,0,1,               1));
    vq.push_back(mk("wr3",    0,1,3,32'h33,      1,0,3,0,0, 32'h0,32'h33,0,0,              32'h0,32'h0,0,1,               0));
    vq.push_back(mk("rd3b",   0,0,0,32'h0,       1,0,3,0,0, 32'h0,32'h33,0,0,              32'h0,32'h33,0,0,              0));
    vq.push_back(mk("lkwr9",  0,1,9,32'h99,      1,9,0,1,9, 32'h99,32'h0,1,0,              32'h0,32'h0,0,0,               1));
    vq.push_back(mk("rd9",    0,0,0,32'h0,       1,9,0,0,0, 32'h99,32'h0,1,0,              32'h99,32'h0,1,0,              1));
    vq.push_back(mk("hold1",  0,1,9,32'hA1,      0,9,0,0,0, 32'h99,32'h0,1,0,              32'h99,32'h0,1,0,              0));
    vq.push_back(mk("hold2",  0,1,9,32'hA2,      0,9,0,0,0, 32'h99,32'h0,1,0,              32'h99,32'h0,1,0,              0));
    vq.push_back(mk("hold3",  0,1,9,32'hA3,      0,9,0,0,0, 32'h99,32'h0,1,0,              32'h99,32'h0,1,0,              0));
    vq.push_back(mk("rd9new", 0,0,0,32'h0,       1,9,0,0,0, 32'hA3,32'h0,0,0,              32'hA3,32'h0,0,0,              0));

    foreach (vq[i]) begin
      set_in(vq[i].rst, vq[i].regw, vq[i].dr, vq[i].din, vq[i].rden,
             vq[i].sr1, vq[i].sr2, vq[i].lock, vq[i].la);
      cycle();
      chk_vec(vq[i]);
    end

    // Fill, lock, then reset with a coincident write and lock.
    for (int i = 1; i < 32; i++) begin
      set_in(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      cycle();
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd31, 1'b1, 5'd4);
    cycle();
    chk("fill rd1 r4", b_rd1, 32'h04040404);
    chk("fill rd2 r31", b_rd2, 32'h1F1F1F1F);
    chk("fill byp p1", 32'(b_p1), 32'd1);
    chk("fill nob p1", 32'(n_p1), 32'd0);
    chk("fill any", 32'(b_any), 32'd1);

    set_in(1'b1, 1'b1, 5'd10, 32'h00000BAD, 1'b1, 5'd4, 5'd10, 1'b1, 5'd6);
    cycle();
    chk("rst rd1", b_rd1, 32'h0);
    chk("rst rd2", b_rd2, 32'h0);
    chk("rst p1", 32'(b_p1), 32'd0);
    chk("rst any", 32'(b_any), 32'd0);
    chk("rst nob any", 32'(n_any), 32'd0);

    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(31 - a), 1'b0, 5'd0);
      cycle();
      chk($sformatf("post-rst rd1 a%0d", a), b_rd1, 32'h0);
      chk($sformatf("post-rst rd2 a%0d", a), b_rd2, 32'h0);
      chk($sformatf("post-rst p1 a%0d", a), 32'(b_p1), 32'd0);
      chk($sformatf("post-rst any a%0d", a), 32'(n_any), 32'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      logic [4:0] dr_r, sr1_r, sr2_r, la_r;
      dr_r  = pick();
      sr1_r = pick();
      sr2_r = ($urandom_range(0, 3) == 0) ? sr1_r : pick();
      la_r  = ($urandom_range(0, 3) == 0) ? dr_r : pick();
      set_in(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), dr_r, $urandom,
             ($urandom_range(0, 3) != 0), sr1_r, sr2_r, ($urandom_range(0, 3) == 0), la_r);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL use these parameters:
- DATA_W, default 32, register width in bits.
- ADDR_W, default 5, address width; depth is 2**ADDR_W.
- ZERO_REG, default 1, 1 = register 0 hardwired to zero.
- BYPASS, default 1, 1 = same-cycle write-to-read forwarding.

REQ-002 The block SHALL have these ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- RegW  in  1  write enable.
- DR  in  ADDR_W  write address.
- Reg_In  in  DATA_W  write data.
- RdEn  in  1  read enable; 0 = read outputs hold.
- SR1  in  ADDR_W  read address, port 1.
- SR2  in  ADDR_W  read address, port 2.
- Lock  in  1  mark register LockAddr as pending (scoreboard set).
- LockAddr  in  ADDR_W  register to mark pending.
- ReadReg1  out  DATA_W  registered read data, port 1.
- ReadReg2  out  DATA_W  registered read data, port 2.
- Pend1  out  1  registered pending flag for SR1.
- Pend2  out  1  registered pending flag for SR2.
- AnyPend  out  1  registered OR of all pending bits.

Function
REQ-003 Storage SHALL be 2**ADDR_W words of DATA_W bits, plus one pending bit per word.
REQ-004 Writes: when RegW=1, REG[DR] <= Reg_In at the clock edge; the write also clears pend[DR].
REQ-005 Lock: when Lock=1, pend[LockAddr] <= 1 at the clock edge.
REQ-006 If Lock and RegW target the same address in the same cycle, the data SHALL be written and the pending bit SHALL end at 1 (set wins).
REQ-007 Reads SHALL have 1-cycle latency; when RdEn=1, ReadReg1/2 <= word SR1/SR2 at the edge.
REQ-008 When RdEn=0, ReadReg1/2 and Pend1/2 SHALL hold their values; writes and locks proceed regardless.
REQ-009 With BYPASS=1, a read with RegW=1 and SRx==DR SHALL return Reg_In, not the old word.
REQ-010 With BYPASS=0, a read with RegW=1 and SRx==DR SHALL return the old word.
REQ-011 Pend1/2 SHALL reflect each pending bit after the same-edge update when BYPASS=1, and before it when BYPASS=0.
REQ-012 With ZERO_REG=1:
- writes and locks to address 0 are ignored;
- reads of address 0 return 0 with Pend=0;
- the bypass never forwards for address 0.
REQ-013 Both read ports SHALL operate independently; SR1==SR2 is legal and returns identical data.
REQ-014 AnyPend SHALL equal the OR of all pending bits after the current edge's updates, computed each cycle regardless of RdEn.
REQ-015 Writing a register that is not pending SHALL be legal and SHALL leave its pending bit at 0.

Reset
REQ-016 When RST=1 at an edge, all words, all pending bits, ReadReg1, ReadReg2, Pend1, Pend2 and AnyPend SHALL become 0.
REQ-017 RST SHALL override RegW, Lock and RdEn in the same cycle; a write or lock coincident with reset SHALL be lost.
REQ-018 In the first cycle after reset deasserts, reads of any address SHALL return 0 with Pend=0.
REQ-019 There SHALL be no initial-value dependence; behaviour before the first reset is undefined.

Verification
REQ-020 The bench SHALL cover these directed scenarios (DATA_W=32, ADDR_W=5):
- Write/read: RegW=1, DR=5, Reg_In=0xDEADBEEF; next cycle RdEn=1, SR1=5 -> ReadReg1=0xDEADBEEF one cycle later.
- Bypass: with REG[7]=0x11, RegW=1, DR=7, Reg_In=0x22 and RdEn=1, SR1=SR2=7 in the same cycle -> BYPASS=1 gives ReadReg1=ReadReg2=0x22; BYPASS=0 gives 0x11.
- Zero register: RegW=1, DR=0, Reg_In=0xFFFFFFFF, then Lock=1, LockAddr=0, then read SR1=0 -> ReadReg1=0, Pend1=0, AnyPend=0.
- Scoreboard: Lock on 3 -> AnyPend=1 and a read of SR2=3 gives Pend2=1; then RegW to DR=3 -> AnyPend=0 and Pend2=0; Lock and RegW both on 9 in one cycle -> pend[9]=1.
- Hold: RdEn=0 for 3 cycles while writing SR1's register -> ReadReg1 unchanged; RdEn=1 -> new value.
- Reset mid-operation: fill registers 1..31 with index*0x01010101 and lock 4; assert RST together with RegW -> all reads return 0, AnyPend=0, the coincident write is absent.
